// File: rtl/adaptive_filter_pkg.sv
// Shared definitions for the adaptive_filter datapath and its downstream stages.
// Sample format is signed Q(W-F).F, two's complement.
package adaptive_filter_pkg;

  localparam int WORDLENGTH_DEFAULT        = 14;
  localparam int FRACTIONAL_LENGTH_DEFAULT = 6;

  typedef logic signed [WORDLENGTH_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry synchronous FIFO with a registered head output.
// A pop and a push in the same cycle are accepted even when full.
module sample_fifo2 #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             pop_ok, push_ok;

  always_comb begin
    pop_ok  = pop_i && (count_q != 2'd0);
    push_ok = push_i && ((count_q != 2'd2) || pop_ok);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) head_d = data_i;
        else                 tail_d = data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the queue simply shifts forward by one.
        if (count_q == 2'd1) begin
          head_d = data_i;
        end else begin
          head_d = tail_q;
          tail_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign data_o  = head_q;
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/filter_decimator.sv
// Averages each group of 2^DECIM_LOG2 valid samples with round-half-up and
// emits the result through a 2-entry buffer; results arriving when it is full are dropped.
module filter_decimator
  import adaptive_filter_pkg::*;
#(
  parameter int WORDLENGTH        = WORDLENGTH_DEFAULT,
  parameter int FRACTIONAL_LENGTH = FRACTIONAL_LENGTH_DEFAULT,
  parameter int DECIM_LOG2        = 2,
  parameter int DROP_CNT_W        = 16
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic signed [WORDLENGTH-1:0] s_tdata,
  input  logic                         s_tvalid,
  output logic signed [WORDLENGTH-1:0] m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         overflow,
  output logic [DROP_CNT_W-1:0]        drop_cnt
);

  localparam int ACC_W = WORDLENGTH + DECIM_LOG2;
  localparam logic [DECIM_LOG2-1:0]   PHASE_LAST = '1;
  localparam logic signed [ACC_W-1:0] HALF       = ACC_W'(2 ** (DECIM_LOG2 - 1));

  if (DECIM_LOG2 < 1 || DECIM_LOG2 > 6 || FRACTIONAL_LENGTH < 0 ||
      FRACTIONAL_LENGTH >= WORDLENGTH) begin : g_param_check
    $error("filter_decimator: illegal parameter set");
  end

  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic signed [ACC_W-1:0]      sum, rounded;
  logic signed [WORDLENGTH-1:0] result;
  logic [DECIM_LOG2-1:0]        phase_q, phase_d;
  logic                         overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0]        drop_cnt_q, drop_cnt_d;
  logic                         push, pop, drop;
  logic                         fifo_full, fifo_empty;
  logic [WORDLENGTH-1:0]        fifo_head;

  always_comb begin
    sum     = acc_q + ACC_W'(s_tdata);
    // The accumulator has headroom for the half-LSB bias, so this cannot wrap.
    rounded = sum + HALF;
    result  = WORDLENGTH'(rounded >>> DECIM_LOG2);
    push    = s_tvalid && (phase_q == PHASE_LAST);
    pop     = !fifo_empty && m_tready;
    drop    = push && fifo_full && !pop;

    acc_d   = acc_q;
    phase_d = phase_q;
    if (s_tvalid) begin
      if (push) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + DECIM_LOG2'(1);
      end
    end

    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_q      <= '0;
      phase_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sample_fifo2 #(
    .WIDTH (WORDLENGTH)
  ) u_fifo (
    .clk     (clk),
    .srst    (srst),
    .push_i  (push),
    .data_i  (result),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_tdata  = fifo_head;
  assign m_tvalid = !fifo_empty;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_filter_decimator.sv
// Bench for filter_decimator: directed cases with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference.
module tb_filter_decimator;
  import adaptive_filter_pkg::*;

  localparam int W = 14;
  localparam int N = 2;
  localparam int D = 1 << N;
  localparam int DROP_MAX = 65535;

  logic            clk;
  logic            srst;
  sample_t         s_tdata;
  logic            s_tvalid;
  logic signed [W-1:0] m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            overflow;
  logic [15:0]     drop_cnt;

  filter_decimator #(
    .WORDLENGTH        (W),
    .FRACTIONAL_LENGTH (6),
    .DECIM_LOG2        (N),
    .DROP_CNT_W        (16)
  ) dut (
    .clk      (clk),
    .srst     (srst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: a group is just a list of samples; its average is floor((sum + D/2) / D).
  int  grp[$];
  int  mq[$];
  bit  m_ovf;
  int  m_drops;
  int  m_sum;
  int  m_res;
  bit  m_have, m_pop, m_full;

  always @(posedge clk) begin
    if (srst) begin
      grp.delete();
      mq.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      m_pop  = (mq.size() != 0) && m_tready;
      m_full = (mq.size() == 2);
      m_have = 1'b0;
      if (s_tvalid) begin
        grp.push_back(int'(s_tdata));
        if (grp.size() == D) begin
          m_sum = 0;
          foreach (grp[k]) m_sum += grp[k];
          m_res  = (m_sum + D / 2) >>> N;
          m_have = 1'b1;
          grp.delete();
        end
      end
      if (m_pop) void'(mq.pop_front());
      if (m_have) begin
        if (!m_full || m_pop) mq.push_back(m_res);
        else begin
          m_ovf = 1'b1;
          if (m_drops != DROP_MAX) m_drops++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_tvalid", m_tvalid, mq.size() != 0);
      if (mq.size() != 0) check("m_tdata", int'(m_tdata), mq[0]);
      check("overflow", overflow, m_ovf);
      check("drop_cnt", drop_cnt, m_drops);
    end
  end

  task automatic step(input bit v, input int d, input bit rdy);
    s_tvalid = v;
    s_tdata  = W'(d);
    m_tready = rdy;
    @(negedge clk);
  endtask

  task automatic group4(input int d, input bit rdy);
    for (int i = 0; i < 4; i++) step(1'b1, d, rdy);
  endtask

  initial begin
    srst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    @(negedge clk);
    step(1'b1, 100, 1'b0);
    srst = 1'b0;
    cmp_en = 1'b1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", int'(m_tdata), 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);

    group4(64, 1'b1);
    check("one_valid", m_tvalid, 1);
    check("one_data", int'(m_tdata), 64);
    step(1'b0, 0, 1'b1);
    check("one_pulse", m_tvalid, 0);

    step(1'b1, 1, 1'b1); step(1'b0, 0, 1'b1);
    step(1'b1, 2, 1'b1); step(1'b0, 0, 1'b1); step(1'b0, 0, 1'b1);
    step(1'b1, 3, 1'b1); step(1'b0, 0, 1'b1);
    step(1'b1, 4, 1'b1);
    check("gaps_data", int'(m_tdata), 3);
    step(1'b0, 0, 1'b1);

    step(1'b1, -1, 1'b1); step(1'b1, -1, 1'b1); step(1'b1, -1, 1'b1); step(1'b1, -2, 1'b1);
    check("neg_round", int'(m_tdata), -1);
    group4(8191, 1'b1);
    check("max_data", int'(m_tdata), 8191);
    group4(-8192, 1'b1);
    check("min_data", int'(m_tdata), -8192);
    step(1'b0, 0, 1'b1);

    group4(4, 1'b0); group4(8, 1'b0); group4(12, 1'b0);
    check("ovf_flag", overflow, 1);
    check("ovf_cnt", drop_cnt, 1);
    check("ovf_head", int'(m_tdata), 4);
    step(1'b0, 0, 1'b1);
    check("ovf_second", int'(m_tdata), 8);
    step(1'b0, 0, 1'b1);
    check("ovf_empty", m_tvalid, 0);

    group4(4, 1'b0); group4(8, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 12, 1'b0);
    step(1'b1, 12, 1'b1);
    check("pp_head", int'(m_tdata), 8);
    check("pp_cnt", drop_cnt, 1);
    step(1'b0, 0, 1'b1);
    check("pp_tail", int'(m_tdata), 12);
    step(1'b0, 0, 1'b1);
    check("pp_empty", m_tvalid, 0);

    step(1'b1, 100, 1'b1); step(1'b1, 100, 1'b1);
    srst = 1'b1;
    step(1'b0, 0, 1'b1);
    srst = 1'b0;
    check("srst_ovf", overflow, 0);
    check("srst_cnt", drop_cnt, 0);
    group4(8, 1'b1);
    check("srst_data", int'(m_tdata), 8);
    step(1'b0, 0, 1'b1);
    check("srst_empty", m_tvalid, 0);

    for (int i = 0; i < 4000; i++) begin
      srst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 16383)),
           $urandom_range(0, 99) < 55);
    end
    srst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/filter_decimator.md
# filter_decimator

Downstream stage of `adaptive_filter`. Consumes the filter's non-stallable valid-only output stream and averages each group of 2^DECIM_LOG2 consecutive valid samples. Emits one rounded Q-format average per group on a ready/valid master interface. A 2-entry output buffer absorbs consumer stalls. When the buffer is full, new results are dropped and counted.

## Interface
- `WORDLENGTH`, 14, total sample width, two's complement
- `FRACTIONAL_LENGTH`, 6, fractional bits; identical on input and output
- `DECIM_LOG2`, 2, log2 of the decimation factor D; legal range 1..6
- `DROP_CNT_W`, 16, width of the drop counter
- `clk`  in  1  clock; all logic on the rising edge
- `srst`  in  1  reset, synchronous, active-high
- `s_tdata`  in  WORDLENGTH  filter output sample, signed Q(W-F).F
- `s_tvalid`  in  1  sample valid; no ready exists, so upstream never stalls
- `m_tdata`  out  WORDLENGTH  averaged sample, same Q format
- `m_tvalid`  out  1  buffer non-empty
- `m_tready`  in  1  consumer accepts the head entry
- `overflow`  out  1  sticky; set on the first dropped result
- `drop_cnt`  out  DROP_CNT_W  number of dropped results; saturates at all-ones

## Operation
- Phase counter `phase` (DECIM_LOG2 bits) counts accepted inputs; the accumulator is WORDLENGTH+DECIM_LOG2 bits, signed.
- On `s_tvalid` with phase≠D-1: acc ← acc + sext(s_tdata); phase++.
- On `s_tvalid` with phase=D-1:
  - sum = acc + sext(s_tdata)
  - result = (sum + 2^(DECIM_LOG2-1)) >>> DECIM_LOG2, which is round-half-up (toward +inf)
  - the result is pushed to the buffer; acc ← 0; phase ← 0
- Width rule: result always fits in WORDLENGTH bits (max·D+D/2 >> N = max; min·D+D/2 >>> N = min). No saturation logic is required.
- Cycles without `s_tvalid` leave acc and phase unchanged. Gaps are allowed anywhere in a group.
- Buffer: 2-entry FIFO, FIFO order. Pop when `m_tvalid & m_tready`.
- Push while full with no pop in the same cycle: the result is discarded, `overflow` ← 1, and `drop_cnt` increments, saturating.
- Push while full with a pop in the same cycle: the push is accepted and nothing is dropped.
- Push and pop while the buffer holds 1 entry: occupancy stays 1 and the new result becomes the head.
- `overflow` and `drop_cnt` clear only on `srst`.

## Timing
- Reset values: `m_tdata`=0, `m_tvalid`=0, `overflow`=0, `drop_cnt`=0; acc=0, phase=0, buffer empty.
- Latency: the D-th valid sample sampled at edge t makes the result visible on `m_tdata` with `m_tvalid`=1 after edge t (registered, 1 cycle) when the buffer was empty.
- `m_tdata` is the head entry. It must hold stable while `m_tvalid & ~m_tready`.
- `m_tvalid` never depends combinationally on `m_tready`.
- Sustained throughput: 1 result per D valid inputs. With `m_tready`=1 continuously, no drops occur for any D≥1.
- `srst` mid-group discards the partial accumulation. The first post-reset group starts at phase 0.
- `srst` asserted together with `s_tvalid`: reset wins and the sample is ignored.

## Structure
- Shared package `adaptive_filter_pkg`: WORDLENGTH/FRACTIONAL_LENGTH defaults and a sample typedef `sample_t` (signed [WORDLENGTH-1:0]). This package is also used by `adaptive_filter` and the benches.
- One sub-module, `sample_fifo2`: 2-entry synchronous FIFO with push/pop/full/empty, parameterised on width.
- Accumulator, rounding, phase counter and drop logic live in `filter_decimator`.

## Test plan
- DECIM_LOG2=2, four valid samples of raw 64 (1.0) back-to-back, `m_tready`=1 -> one output of raw 64, `m_tvalid` high for exactly 1 cycle, 1 cycle after the 4th input.
- Raw inputs 1,2,3,4 with idle gaps between them -> output 3 (12>>2). Raw inputs -1,-1,-1,-2 -> output -1 ((-5+2)>>>2).
- Extremes: four samples of 0x1FFF -> 0x1FFF. Four samples of 0x2000 (-8192) -> 0x2000. No wrap in either case.
- `m_tready`=0 and 12 consecutive inputs of raw 4,8,12 (4 samples each):
  - two results are buffered; the third is dropped, `overflow`=1, `drop_cnt`=1
  - then raise `m_tready` -> outputs 4 then 8 on consecutive cycles, then `m_tvalid`=0
- Full buffer with a pop in the same cycle as a push -> no drop; order preserved.
- Two samples of raw 100, then a 1-cycle `srst`, then four samples of raw 8 -> single output 8. Flags and counter read 0 after reset.
